// File: rtl/ibex_wb_data_bridge_if.sv
// Wishbone B4 pipelined bus bundle between the Ibex data bridge (master)
// and the system interconnect (slave).
interface ibex_wb_data_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW-1:0]   wb_dat_i;
  logic            wb_stall_i;
  logic            wb_ack_i;
  logic            wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    input  wb_dat_i, wb_stall_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o,
    output wb_dat_i, wb_stall_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/ibex_wb_data_bridge.sv
// Ibex data port (req/gnt/rvalid) to Wishbone B4 pipelined master with
// multiple outstanding transactions, bus-error forwarding and a response watchdog.
module ibex_wb_data_bridge #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MaxOutstanding = 2,
  parameter int TimeoutCycles  = 1024,
  localparam int CntW          = $clog2(MaxOutstanding + 1),
  localparam int WdW           = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_i,
  output logic                  gnt_o,
  input  logic                  we_i,
  input  logic [DW/8-1:0]       be_i,
  input  logic [AW-1:0]         addr_i,
  input  logic [DW-1:0]         wdata_i,
  output logic                  rvalid_o,
  output logic [DW-1:0]         rdata_o,
  output logic                  err_o,
  ibex_wb_data_bridge_if.master wb,
  output logic [CntW-1:0]       outstanding_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ABORT  = 2'd2
  } state_e;

  state_e         state_r, state_next_s;
  logic [CntW-1:0] cnt_r, cnt_next_s;
  logic [WdW-1:0]  wd_r, wd_next_s;
  logic            timeout_r;

  logic abort_s, full_s, busy_s, stb_s, gnt_s, rsp_s, expire_s;

  assign abort_s = (state_r == ABORT);
  assign full_s  = (cnt_r == CntW'(MaxOutstanding));
  assign busy_s  = (cnt_r != {CntW{1'b0}});
  // No bypass when full: a response in the same cycle does not open the strobe.
  assign stb_s   = req_i & ~full_s & ~abort_s;
  assign gnt_s   = stb_s & ~wb.wb_stall_i;
  // Responses with nothing outstanding, or while aborting, are dropped.
  assign rsp_s   = (wb.wb_ack_i | wb.wb_err_i) & busy_s & ~abort_s;

  assign expire_s = (TimeoutCycles != 0) && (state_r == ACTIVE) &&
                    (wd_r == WdW'(TimeoutCycles - 1)) && !rsp_s;

  assign wb.wb_cyc_o = stb_s | (busy_s & ~abort_s);
  assign wb.wb_stb_o = stb_s;
  assign wb.wb_we_o  = we_i;
  assign wb.wb_sel_o = be_i;
  assign wb.wb_adr_o = addr_i;
  assign wb.wb_dat_o = wdata_i;

  assign gnt_o         = gnt_s;
  assign outstanding_o = cnt_r;
  assign timeout_o     = timeout_r;

  // Core-side response: bus response normally, synthetic error per entry in ABORT.
  always_comb begin
    rvalid_o = 1'b0;
    err_o    = 1'b0;
    rdata_o  = wb.wb_dat_i;
    if (abort_s) begin
      rvalid_o = 1'b1;
      err_o    = 1'b1;
      rdata_o  = {DW{1'b0}};
    end else begin
      rvalid_o = rsp_s;
      err_o    = rsp_s & wb.wb_err_i;
    end
  end

  // Outstanding count and watchdog next values.
  always_comb begin
    cnt_next_s = cnt_r;
    wd_next_s  = {WdW{1'b0}};
    if (abort_s) begin
      if (busy_s) begin
        cnt_next_s = cnt_r - CntW'(1);
      end else begin
        cnt_next_s = cnt_r;
      end
    end else begin
      cnt_next_s = cnt_r + CntW'(gnt_s) - CntW'(rsp_s);
    end
    if ((TimeoutCycles != 0) && (state_r == ACTIVE) && !rsp_s && !gnt_s && !expire_s) begin
      wd_next_s = wd_r + WdW'(1);
    end else begin
      wd_next_s = {WdW{1'b0}};
    end
  end

  // Next-state logic of the bridge FSM.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_s) state_next_s = ACTIVE;
        else       state_next_s = IDLE;
      end
      ACTIVE: begin
        if (cnt_next_s == {CntW{1'b0}}) state_next_s = IDLE;
        else if (expire_s)              state_next_s = ABORT;
        else                            state_next_s = ACTIVE;
      end
      ABORT: begin
        if (cnt_next_s == {CntW{1'b0}}) state_next_s = IDLE;
        else                            state_next_s = ABORT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight transaction without a response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= {CntW{1'b0}};
      wd_r      <= {WdW{1'b0}};
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      cnt_r     <= cnt_next_s;
      wd_r      <= wd_next_s;
      timeout_r <= expire_s;
    end
  end

endmodule

// File: tb/tb_ibex_wb_data_bridge.sv
// Directed self-checking bench for ibex_wb_data_bridge (MaxOutstanding=2, TimeoutCycles=8).
module tb_ibex_wb_data_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, we;
  logic [3:0]  be;
  logic [31:0] addr, wdata;
  logic        gnt, rvalid, err, timeout;
  logic [31:0] rdata;
  logic [1:0]  outstanding;

  int errors = 0;
  int checks = 0;

  ibex_wb_data_bridge_if #(.AW(32), .DW(32)) wb_bus ();

  ibex_wb_data_bridge #(
    .AW(32), .DW(32), .MaxOutstanding(2), .TimeoutCycles(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .gnt_o(gnt), .we_i(we), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .wb(wb_bus), .outstanding_o(outstanding), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  // Move to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (wb_bus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL reset_cyc: got %b want 0", wb_bus.wb_cyc_o); end
    checks++; if (wb_bus.wb_stb_o !== 1'b0) begin errors++; $display("FAIL reset_stb: got %b want 0", wb_bus.wb_stb_o); end
    checks++; if (gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b want 0", gnt); end
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rvalid); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", outstanding); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout); end
    next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    next_cycle(); req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0000_0100; #2;
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt: got %b want 1", gnt); end
    checks++; if (wb_bus.wb_adr_o !== 32'h0000_0100) begin errors++; $display("FAIL rd_adr: got %h want 00000100", wb_bus.wb_adr_o); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL rd_cnt0: got %0d want 0", outstanding); end
    next_cycle(); req = 1'b0; wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'hDEAD_BEEF; #2;
    checks++; if (rvalid !== 1'b1) begin errors++; $display("FAIL rd_rvalid: got %b want 1", rvalid); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_rdata: got %h want deadbeef", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rd_err: got %b want 0", err); end
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL rd_cnt1: got %0d want 1", outstanding); end
    next_cycle(); wb_bus.wb_ack_i = 1'b0; #2;
    checks++; if (wb_bus.wb_cyc_o !== 1'b0) begin errors++; $display("FAIL rd_cyc_drop: got %b want 0", wb_bus.wb_cyc_o); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL rd_cnt2: got %0d want 0", outstanding); end
  endtask

  task automatic test_back_to_back();
    bit [6:0] e_gnt = 7'b0010011;
    bit [6:0] e_rv  = 7'b0111000;
    bit [6:0] e_cyc = 7'b0111111;
    int       e_cnt [7] = '{0, 1, 2, 2, 1, 1, 0};
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      req  = (c < 5);
      addr = (c < 2) ? 32'h10 + 32'(4 * c) : 32'h18;
      wb_bus.wb_ack_i = (c >= 3) && (c <= 5);
      wb_bus.wb_dat_i = 32'hA000_0000 + 32'(c);
      #2;
      checks++; if (gnt !== e_gnt[c]) begin errors++; $display("FAIL b2b_gnt c%0d: got %b want %b", c, gnt, e_gnt[c]); end
      checks++; if (wb_bus.wb_stb_o !== e_gnt[c]) begin errors++; $display("FAIL b2b_stb c%0d: got %b want %b", c, wb_bus.wb_stb_o, e_gnt[c]); end
      checks++; if (wb_bus.wb_cyc_o !== e_cyc[c]) begin errors++; $display("FAIL b2b_cyc c%0d: got %b want %b", c, wb_bus.wb_cyc_o, e_cyc[c]); end
      checks++; if (outstanding !== 2'(e_cnt[c])) begin errors++; $display("FAIL b2b_cnt c%0d: got %0d want %0d", c, outstanding, e_cnt[c]); end
      checks++; if (rvalid !== e_rv[c]) begin errors++; $display("FAIL b2b_rvalid c%0d: got %b want %b", c, rvalid, e_rv[c]); end
      if (e_rv[c]) begin
        checks++; if (rdata !== 32'hA000_0000 + 32'(c)) begin errors++; $display("FAIL b2b_rdata c%0d: got %h want %h", c, rdata, 32'hA000_0000 + 32'(c)); end
      end
    end
    wb_bus.wb_ack_i = 1'b0;
  endtask

  task automatic test_stall();
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      req = 1'b1; we = 1'b1; be = 4'hC; addr = 32'h0000_0200; wdata = 32'h1234_5678;
      wb_bus.wb_stall_i = (c < 4);
      #2;
      checks++; if (gnt !== (c == 4)) begin errors++; $display("FAIL stall_gnt c%0d: got %b want %b", c, gnt, (c == 4)); end
      checks++; if ({wb_bus.wb_stb_o, wb_bus.wb_cyc_o} !== 2'b11) begin errors++; $display("FAIL stall_stbcyc c%0d: got %b want 11", c, {wb_bus.wb_stb_o, wb_bus.wb_cyc_o}); end
      checks++; if ({wb_bus.wb_we_o, wb_bus.wb_sel_o, wb_bus.wb_dat_o} !== {1'b1, 4'hC, 32'h1234_5678}) begin errors++; $display("FAIL stall_data c%0d: got %h want 1c12345678", c, {wb_bus.wb_we_o, wb_bus.wb_sel_o, wb_bus.wb_dat_o}); end
    end
    next_cycle(); req = 1'b0; wb_bus.wb_stall_i = 1'b0; wb_bus.wb_ack_i = 1'b1; #2;
    checks++; if ({rvalid, err} !== 2'b10) begin errors++; $display("FAIL stall_rsp: got %b want 10", {rvalid, err}); end
    next_cycle(); wb_bus.wb_ack_i = 1'b0;
  endtask

  task automatic test_bus_error();
    next_cycle(); req = 1'b1; we = 1'b1; be = 4'h3; addr = 32'h0000_0300; #2;
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL berr_gnt: got %b want 1", gnt); end
    next_cycle(); req = 1'b0; wb_bus.wb_ack_i = 1'b1; wb_bus.wb_err_i = 1'b1; #2;
    checks++; if ({rvalid, err} !== 2'b11) begin errors++; $display("FAIL berr_rsp: got %b want 11", {rvalid, err}); end
    checks++; if (outstanding !== 2'd1) begin errors++; $display("FAIL berr_cnt1: got %0d want 1", outstanding); end
    next_cycle(); wb_bus.wb_ack_i = 1'b0; wb_bus.wb_err_i = 1'b0; #2;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL berr_single: got %b want 0", rvalid); end
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL berr_cnt0: got %0d want 0", outstanding); end
  endtask

  task automatic test_watchdog();
    we = 1'b0; be = 4'hF;
    for (int c = 0; c < 2; c++) begin
      next_cycle(); req = 1'b1; addr = 32'h400 + 32'(4 * c); #2;
      checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL wd_gnt c%0d: got %b want 1", c, gnt); end
    end
    for (int c = 2; c < 10; c++) begin
      next_cycle(); req = 1'b0; #2;
      checks++; if ({timeout, rvalid, wb_bus.wb_cyc_o, outstanding} !== 5'b00110) begin errors++; $display("FAIL wd_wait c%0d: got %b want 00110", c, {timeout, rvalid, wb_bus.wb_cyc_o, outstanding}); end
    end
    next_cycle(); req = 1'b1; wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'hFFFF_FFFF; #2;
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL wd_timeout: got %b want 1", timeout); end
    checks++; if ({wb_bus.wb_cyc_o, wb_bus.wb_stb_o, gnt} !== 3'b000) begin errors++; $display("FAIL wd_abort_bus: got %b want 000", {wb_bus.wb_cyc_o, wb_bus.wb_stb_o, gnt}); end
    checks++; if ({rvalid, err, outstanding} !== 4'b1110) begin errors++; $display("FAIL wd_abort_rsp0: got %b want 1110", {rvalid, err, outstanding}); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL wd_abort_rdata: got %h want 00000000", rdata); end
    next_cycle(); req = 1'b0; wb_bus.wb_ack_i = 1'b0; #2;
    checks++; if ({timeout, rvalid, err, outstanding} !== 5'b01101) begin errors++; $display("FAIL wd_abort_rsp1: got %b want 01101", {timeout, rvalid, err, outstanding}); end
    next_cycle(); req = 1'b1; addr = 32'h500; #2;
    checks++; if ({rvalid, outstanding, gnt, timeout} !== 5'b00010) begin errors++; $display("FAIL wd_idle: got %b want 00010", {rvalid, outstanding, gnt, timeout}); end
    next_cycle(); req = 1'b0; wb_bus.wb_ack_i = 1'b1; wb_bus.wb_dat_i = 32'h55; #2;
    checks++; if ({rvalid, err} !== 2'b10 || rdata !== 32'h55) begin errors++; $display("FAIL wd_recover: got %b %h want 10 00000055", {rvalid, err}, rdata); end
    next_cycle(); wb_bus.wb_ack_i = 1'b0;
  endtask

  task automatic test_spurious_and_reset();
    next_cycle(); wb_bus.wb_ack_i = 1'b1; #2;
    checks++; if ({rvalid, wb_bus.wb_cyc_o} !== 2'b00) begin errors++; $display("FAIL spur_rvalid: got %b want 00", {rvalid, wb_bus.wb_cyc_o}); end
    next_cycle(); wb_bus.wb_ack_i = 1'b0; #2;
    checks++; if (outstanding !== 2'd0) begin errors++; $display("FAIL spur_cnt: got %0d want 0", outstanding); end
    for (int c = 0; c < 2; c++) begin
      next_cycle(); req = 1'b1; addr = 32'h600 + 32'(4 * c);
    end
    next_cycle(); req = 1'b0; #1;
    checks++; if (outstanding !== 2'd2) begin errors++; $display("FAIL rst_pre_cnt: got %0d want 2", outstanding); end
    rst_n = 1'b0; #1;
    checks++; if ({outstanding, wb_bus.wb_cyc_o} !== 3'b000) begin errors++; $display("FAIL rst_async: got %b want 000", {outstanding, wb_bus.wb_cyc_o}); end
    wb_bus.wb_ack_i = 1'b1; #1;
    checks++; if (rvalid !== 1'b0) begin errors++; $display("FAIL rst_no_rsp: got %b want 0", rvalid); end
    next_cycle(); rst_n = 1'b1; wb_bus.wb_ack_i = 1'b0; #2;
    checks++; if ({outstanding, wb_bus.wb_cyc_o, rvalid} !== 4'b0000) begin errors++; $display("FAIL rst_after: got %b want 0000", {outstanding, wb_bus.wb_cyc_o, rvalid}); end
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;
    wb_bus.wb_dat_i = 32'h0; wb_bus.wb_stall_i = 1'b0;
    wb_bus.wb_ack_i = 1'b0;  wb_bus.wb_err_i = 1'b0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_bus_error();
    test_watchdog();
    test_spurious_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ibex_wb_data_bridge.md
Name: ibex_wb_data_bridge

Overview:
Parametrised bridge from the Ibex data port (req/gnt/rvalid handshake) to a Wishbone B4 pipelined master.
It generalises the existing single-transaction glue in three ways:
- multiple outstanding transactions, tracked by a counter;
- bus-error propagation from wb_err_i;
- a response watchdog that aborts a hung cycle and returns error responses to the core.

It sits between the Ibex core data port and the system Wishbone interconnect. The instruction-port variant is a later instance with we_i tied low.

Parameters:
AW, 32, address width in bits.
DW, 32, data width in bits; a multiple of 8.
MaxOutstanding, 2, maximum number of accepted-but-unanswered transactions; must be ≥1.
TimeoutCycles, 1024, number of consecutive response-less cycles, with outstanding>0, before an abort; 0 disables the watchdog.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_i  in  1  core request valid
gnt_o  out  1  request accepted this cycle
we_i  in  1  write enable
be_i  in  DW/8  byte enables
addr_i  in  AW  byte address
wdata_i  in  DW  write data
rvalid_o  out  1  response valid, one cycle per accepted request
rdata_o  out  DW  read data
err_o  out  1  response is an error (qualified by rvalid_o)
wb_cyc_o  out  1  Wishbone cycle
wb_stb_o  out  1  Wishbone strobe
wb_we_o  out  1  Wishbone write enable
wb_sel_o  out  DW/8  Wishbone byte select
wb_adr_o  out  AW  Wishbone address
wb_dat_o  out  DW  Wishbone write data
wb_dat_i  in  DW  Wishbone read data
wb_stall_i  in  1  Wishbone stall
wb_ack_i  in  1  Wishbone acknowledge
wb_err_i  in  1  Wishbone error
outstanding_o  out  $clog2(MaxOutstanding+1)  current outstanding count
timeout_o  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Registered state:
  - outstanding count `cnt`;
  - watchdog counter `wd`;
  - FSM state in {IDLE, ACTIVE, ABORT}.
- Reset: cnt=0, wd=0, state=IDLE, timeout_o=0. In reset with req_i=0, the outputs wb_cyc_o, wb_stb_o, gnt_o and rvalid_o are all 0.
- Pass-through: wb_adr_o, wb_dat_o, wb_we_o and wb_sel_o are driven combinationally from addr_i, wdata_i, we_i and be_i. There is no address alignment; the consumer uses wb_sel_o.
- Strobe and grant:
  - full = (cnt == MaxOutstanding).
  - wb_stb_o = req_i & ~full & (state != ABORT).
  - gnt_o = wb_stb_o & ~wb_stall_i. Issue has zero latency: the request is accepted in the same cycle.
  - A full bridge does not bypass: stb stays 0 while full, even if a response arrives in that cycle.
- Cycle: wb_cyc_o = wb_stb_o | (cnt != 0 & state != ABORT).
- Response, rsp = (wb_ack_i | wb_err_i) & (cnt != 0) & (state != ABORT):
  - rvalid_o = rsp; err_o = rsp & wb_err_i. If ack and err are both high, the response counts once, as an error.
  - rdata_o = wb_dat_i, valid only when rvalid_o is 1.
  - ack or err while cnt==0 is spurious and is ignored: no rvalid, no count change.
- Counter update: cnt_next = cnt + gnt_o − rsp. A grant and a response in the same cycle leave cnt unchanged. cnt never exceeds MaxOutstanding and never drops below 0.
- FSM:
  - IDLE → ACTIVE on gnt_o.
  - ACTIVE → IDLE when cnt_next == 0.
  - ACTIVE → ABORT when TimeoutCycles != 0 and wd reaches TimeoutCycles−1 with no rsp in that cycle. timeout_o pulses for 1 cycle on this transition.
  - ABORT: wb_cyc_o=0, wb_stb_o=0, gnt_o=0, and all Wishbone responses are ignored. Each cycle the bridge emits rvalid_o=1, err_o=1, rdata_o=0 and decrements cnt. When cnt reaches 0 it moves to IDLE, so ABORT lasts exactly cnt cycles.
- Watchdog:
  - wd increments each ACTIVE cycle without rsp.
  - wd clears on any rsp, on any gnt_o, and in IDLE/ABORT.
  - wd width is $clog2(TimeoutCycles+1).
- Reset asserted mid-transaction: all state clears immediately. In-flight transactions are dropped with no response, since the core resets simultaneously.
- outstanding_o = cnt.

Test Plan:
1. Single read: req_i=1, addr=0x100, stall=0; ack on the next cycle with dat=0xDEADBEEF → gnt_o=1 in cycle 0; rvalid_o=1, rdata_o=0xDEADBEEF, err_o=0 in cycle 1; cyc drops in cycle 2; outstanding_o goes 0→1→0.
2. Pipelined back-to-back: MaxOutstanding=2, three requests held, ack delayed 3 cycles → the first two are granted on consecutive cycles; the third stalls (stb=0) until the first ack, then is granted the cycle after; three rvalids in order; cnt never exceeds 2.
3. Stall: wb_stall_i=1 for 4 cycles with req_i=1 → stb=1, cyc=1, gnt_o=0 throughout; grant on the 5th cycle when stall drops; write data and sel are held stable from addr_i/wdata_i.
4. Bus error: write with be=0x3, slave asserts err (and ack in the same cycle) → exactly one rvalid_o with err_o=1; cnt 1→0.
5. Watchdog: TimeoutCycles=8, two requests granted, no response → timeout_o pulses when wd reaches 7; cyc=0 in ABORT; two consecutive rvalid_o cycles with err_o=1 and rdata_o=0; a late ack in ABORT is ignored; state returns to IDLE with cnt=0.
6. Spurious and reset: ack with cnt=0 → no rvalid_o. Assert rst_n=0 with cnt=2 → cnt=0, cyc=0 asynchronously, no responses emitted.
